// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core control path: FSM states, opcodes, mux/ALU codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a; consumers import this so alu_op and select encodings agree everywhere.
package mc_pkg;

  // Controller states; the encodings are visible on the debug state port.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  // Supported opcodes, instr[6:0].
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // alu_op codes consumed by the ALU decoder.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU operand A select.
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Result bus select.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Full control word for one state, before stall/reset gating.
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  // DECODE dispatch: first execution state for an opcode; unknown opcodes trap.
  function automatic state_e decode_dispatch(input logic [6:0] op);
    state_e nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_R:         nxt = S_EXECUTER;
      OP_I:         nxt = S_EXECUTEI;
      OP_BEQ:       nxt = S_BEQ;
      OP_JAL:       nxt = S_JAL;
      default:      nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_out_dec.sv
// Moore output decoder: maps the current controller state to its ungated control word.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the FSM applies stall/reset gating around this map.
module mc_out_dec
  import mc_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // Per-state control word; every field defaults to 0 so unlisted outputs stay low.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.adr_src    = 1'b0;
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.alu_src_a  = SRC_A_PC;
        ctrl_o.alu_src_b  = SRC_B_FOUR;
        ctrl_o.alu_op     = ALU_OP_ADD;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.pc_update  = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch/jump target OldPC + imm while the opcode is decoded.
        ctrl_o.alu_src_a = SRC_A_OLDPC;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRC_A_RS1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_o.alu_src_a = SRC_A_RS1;
        ctrl_o.alu_src_b = SRC_B_RS2;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl_o.alu_src_a = SRC_A_RS1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_BEQ: begin
        // Compare rs1 - rs2; PC takes the DECODE-computed target held in ALUOut if Zero.
        ctrl_o.alu_src_a  = SRC_A_RS1;
        ctrl_o.alu_src_b  = SRC_B_RS2;
        ctrl_o.alu_op     = ALU_OP_SUB;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.branch     = 1'b1;
      end
      S_JAL: begin
        // PC <= target from ALUOut while the ALU forms the link value OldPC + 4.
        ctrl_o.alu_src_a  = SRC_A_OLDPC;
        ctrl_o.alu_src_b  = SRC_B_FOUR;
        ctrl_o.alu_op     = ALU_OP_ADD;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_update  = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle RISC-V core (lw, sw, R, I-ALU, beq, jal).
// Latency: beq 3, sw/R/I/jal 4, lw 5 cycles per instruction; outputs are Moore on state.
// Backpressure: en=0 holds the state and kills all strobes while selects stay stable.
module mc_main_fsm
  import mc_pkg::*;
#(
  parameter logic HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] op,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       reg_write,
  output logic       mem_write,
  output logic       branch,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   strobe_kill;

  // Next-state logic; op only matters in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = decode_dispatch(op);
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          // Opcode changed under us after DECODE; trap rather than guess.
          state_d = S_ILLEGAL;
        end
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register: reset wins over stall and any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  mc_out_dec u_out_dec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Strobes are killed on stall or reset so a held cycle never repeats a write.
  assign strobe_kill = reset | ~en;

  // Output gating: selects pass through unchanged, strobes and illegal are masked.
  always_comb begin
    alu_op     = ctrl.alu_op;
    alu_src_a  = ctrl.alu_src_a;
    alu_src_b  = ctrl.alu_src_b;
    result_src = ctrl.result_src;
    adr_src    = ctrl.adr_src;
    ir_write   = ctrl.ir_write  & ~strobe_kill;
    pc_update  = ctrl.pc_update & ~strobe_kill;
    reg_write  = ctrl.reg_write & ~strobe_kill;
    mem_write  = ctrl.mem_write & ~strobe_kill;
    branch     = ctrl.branch    & ~strobe_kill;
    illegal    = ctrl.illegal   & ~reset;
    state      = state_q;
  end

endmodule
